// File: rtl/load_use_hazard_unit_if.sv
// rtl/load_use_hazard_unit_if.sv - decode/interlock signal bundle for the load-use hazard unit
interface load_use_hazard_unit_if;
  logic        dec_valid;
  logic [3:0]  dec_r2;
  logic [3:0]  dec_r3;
  logic        dec_vf;
  logic [1:0]  dec_ext_sel;
  logic [3:0]  dec_dest;
  logic        dec_we;
  logic        dec_is_load;
  logic        mem_hold;
  logic        stall;
  logic        bubble;
  logic        load_pending;
  logic [15:0] stall_count;

  // Decode stage side: presents the instruction, receives the interlock.
  modport master (
    output dec_valid, dec_r2, dec_r3, dec_vf, dec_ext_sel,
           dec_dest, dec_we, dec_is_load, mem_hold,
    input  stall, bubble, load_pending, stall_count
  );

  // Hazard unit side.
  modport slave (
    input  dec_valid, dec_r2, dec_r3, dec_vf, dec_ext_sel,
           dec_dest, dec_we, dec_is_load, mem_hold,
    output stall, bubble, load_pending, stall_count
  );
endinterface

// File: rtl/load_use_hazard_unit.sv
// rtl/load_use_hazard_unit.sv - decode-stage load-use interlock with per-register countdowns
module load_use_hazard_unit #(
  parameter int NREG     = 16,
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = $clog2(LOAD_LAT + 1)
) (
  input logic                   clk,
  input logic                   rst,
  load_use_hazard_unit_if.slave hz
);

  localparam logic [CNT_W-1:0] LAT_VAL = CNT_W'(LOAD_LAT);

  // cnt[bank][reg]: cycles until the loaded value reaches the forwarding point.
  logic [CNT_W-1:0] cnt [2][NREG];
  logic [NREG-1:0]  pend [2];
  logic             hz2;
  logic             hz3;
  logic             stall_int;
  logic             issue;
  logic             load_set;
  logic             any_pend;
  logic [15:0]      stall_cnt_q;

  // Pending map from countdown state; index 0 is hardwired never-pending.
  always_comb begin
    any_pend = 1'b0;
    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < NREG; i++) begin
        pend[v][i] = (i != 0) && (cnt[v][i] != '0);
        any_pend   = any_pend | pend[v][i];
      end
    end
  end

  // Source-operand hazard check, gated by the operand format and bank.
  always_comb begin
    hz2       = (hz.dec_r2 != 4'd0) & ~hz.dec_ext_sel[1]
              & pend[hz.dec_vf][hz.dec_r2];
    hz3       = (hz.dec_r3 != 4'd0) & (hz.dec_ext_sel == 2'b00)
              & pend[hz.dec_vf][hz.dec_r3];
    stall_int = hz.dec_valid & (hz2 | hz3);
    issue     = hz.dec_valid & ~stall_int & ~hz.mem_hold;
    load_set  = issue & hz.dec_we & hz.dec_is_load & (hz.dec_dest != 4'd0);
  end

  // Countdowns: freeze on mem_hold, otherwise decrement, and (re)arm on an issuing load.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < 2; v++) begin
        for (int i = 0; i < NREG; i++) begin
          cnt[v][i] <= '0;
        end
      end
    end else if (!hz.mem_hold) begin
      for (int v = 0; v < 2; v++) begin
        for (int i = 0; i < NREG; i++) begin
          if (load_set && (hz.dec_vf == v[0]) && (hz.dec_dest == i[3:0])) begin
            cnt[v][i] <= LAT_VAL;
          end else if (cnt[v][i] != '0) begin
            cnt[v][i] <= cnt[v][i] - 1'b1;
          end
        end
      end
    end
  end

  // Saturating count of stall cycles that actually cost a pipeline slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
    end else if (stall_int && !hz.mem_hold && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign hz.stall        = stall_int;
  assign hz.bubble       = stall_int;
  assign hz.load_pending = any_pend;
  assign hz.stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_load_use_hazard_unit.sv
// tb/tb_load_use_hazard_unit.sv - table/scoreboard bench for load_use_hazard_unit
module tb_load_use_hazard_unit;

  typedef struct {
    int          idx;
    logic        rst;
    logic        valid;
    logic [3:0]  r2;
    logic [3:0]  r3;
    logic        vf;
    logic [1:0]  ext;
    logic [3:0]  dest;
    logic        we;
    logic        ld;
    logic        hold;
    logic        es;
    logic        ep;
    logic [15:0] ec;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic big_rst = 1'b1;
  int   n_checks = 0;
  int   n_err = 0;

  vec_t tbl[$];
  vec_t sb[$];

  load_use_hazard_unit_if u_if ();
  load_use_hazard_unit_if b_if ();

  load_use_hazard_unit u_dut (
    .clk (clk),
    .rst (rst),
    .hz  (u_if)
  );

  load_use_hazard_unit #(.LOAD_LAT(40000)) u_big (
    .clk (clk),
    .rst (big_rst),
    .hz  (b_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic rst_i, input logic val_i, input logic [3:0] r2_i, input logic [3:0] r3_i,
    input logic vf_i, input logic [1:0] ext_i, input logic [3:0] dest_i, input logic we_i,
    input logic ld_i, input logic hold_i, input logic es_i, input logic ep_i,
    input logic [15:0] ec_i);
    vec_t v;
    v.idx = 0;     v.rst = rst_i;  v.valid = val_i; v.r2 = r2_i; v.r3 = r3_i;
    v.vf = vf_i;   v.ext = ext_i;  v.dest = dest_i; v.we = we_i; v.ld = ld_i;
    v.hold = hold_i; v.es = es_i;  v.ep = ep_i;     v.ec = ec_i;
    return v;
  endfunction

  // Scoreboard consumer: expected outputs for the current cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      vec_t e;
      e = sb.pop_front();
      chk($sformatf("row%0d stall", e.idx), {31'd0, u_if.stall}, {31'd0, e.es});
      chk($sformatf("row%0d bubble", e.idx), {31'd0, u_if.bubble}, {31'd0, e.es});
      chk($sformatf("row%0d load_pending", e.idx), {31'd0, u_if.load_pending}, {31'd0, e.ep});
      chk($sformatf("row%0d stall_count", e.idx), {16'd0, u_if.stall_count}, {16'd0, e.ec});
    end
  end

  task automatic big_drive(input logic val_i, input logic [3:0] r2_i, input logic [3:0] dest_i,
                           input logic ld_i);
    b_if.dec_valid = val_i; b_if.dec_r2 = r2_i; b_if.dec_r3 = 4'd0; b_if.dec_vf = 1'b0;
    b_if.dec_ext_sel = 2'b00; b_if.dec_dest = dest_i; b_if.dec_we = val_i;
    b_if.dec_is_load = ld_i; b_if.mem_hold = 1'b0;
  endtask

  initial begin
    int n;
    u_if.dec_valid = 1'b0; u_if.dec_r2 = 4'd0; u_if.dec_r3 = 4'd0; u_if.dec_vf = 1'b0;
    u_if.dec_ext_sel = 2'b00; u_if.dec_dest = 4'd0; u_if.dec_we = 1'b0;
    u_if.dec_is_load = 1'b0; u_if.mem_hold = 1'b0;
    big_drive(1'b0, 4'd0, 4'd0, 1'b0);

    // rst, valid, r2, r3, vf, ext, dest, we, ld, hold | stall, pending, count
    // reset held with a valid R3 reader
    tbl.push_back(mk(1,1,0,3,0,2'b00,0,0,0,0, 0,0,16'd0));
    tbl.push_back(mk(1,1,0,3,0,2'b00,0,0,0,0, 0,0,16'd0));
    // basic load-use, vector bank dest 4
    tbl.push_back(mk(0,1,0,0,1,2'b00,4,1,1,0, 0,0,16'd0));
    tbl.push_back(mk(0,1,4,0,1,2'b00,5,1,0,0, 1,1,16'd0));
    tbl.push_back(mk(0,1,4,0,1,2'b00,5,1,0,0, 1,1,16'd1));
    tbl.push_back(mk(0,1,4,0,1,2'b00,5,1,0,0, 0,0,16'd2));
    tbl.push_back(mk(0,0,0,0,0,2'b00,0,0,0,0, 0,0,16'd2));
    // filtering: other bank, ext 10, ext 01 on R3, R2=0, dest 0 ignored, R3 hazard
    tbl.push_back(mk(0,1,0,0,1,2'b00,4,1,1,0, 0,0,16'd2));
    tbl.push_back(mk(0,1,4,0,0,2'b00,5,1,0,0, 0,1,16'd2));
    tbl.push_back(mk(0,1,4,4,1,2'b10,4,1,1,0, 0,1,16'd2));
    tbl.push_back(mk(0,1,0,4,1,2'b01,4,1,1,0, 0,1,16'd2));
    tbl.push_back(mk(0,1,0,0,1,2'b00,0,1,1,0, 0,1,16'd2));
    tbl.push_back(mk(0,1,1,4,1,2'b00,5,1,0,0, 1,1,16'd2));
    tbl.push_back(mk(0,1,1,4,1,2'b00,5,1,0,0, 0,0,16'd3));
    // mem_hold across a stall, then a load blocked by mem_hold
    tbl.push_back(mk(0,1,0,0,0,2'b00,6,1,1,0, 0,0,16'd3));
    tbl.push_back(mk(0,1,6,0,0,2'b00,5,1,0,1, 1,1,16'd3));
    tbl.push_back(mk(0,1,6,0,0,2'b00,5,1,0,1, 1,1,16'd3));
    tbl.push_back(mk(0,1,6,0,0,2'b00,5,1,0,1, 1,1,16'd3));
    tbl.push_back(mk(0,1,6,0,0,2'b00,5,1,0,0, 1,1,16'd3));
    tbl.push_back(mk(0,1,6,0,0,2'b00,5,1,0,0, 1,1,16'd4));
    tbl.push_back(mk(0,1,6,0,0,2'b00,5,1,0,0, 0,0,16'd5));
    tbl.push_back(mk(0,1,0,0,0,2'b00,6,1,1,1, 0,0,16'd5));
    tbl.push_back(mk(0,0,0,0,0,2'b00,0,0,0,0, 0,0,16'd5));
    // re-load of dest 7 restarts the countdown
    tbl.push_back(mk(0,1,0,0,0,2'b00,7,1,1,0, 0,0,16'd5));
    tbl.push_back(mk(0,1,0,0,0,2'b00,7,1,1,0, 0,1,16'd5));
    tbl.push_back(mk(0,1,7,0,0,2'b00,5,1,0,0, 1,1,16'd5));
    tbl.push_back(mk(0,1,7,0,0,2'b00,5,1,0,0, 1,1,16'd6));
    tbl.push_back(mk(0,1,7,0,0,2'b00,5,1,0,0, 0,0,16'd7));
    // ALU write never arms a countdown
    tbl.push_back(mk(0,1,0,0,0,2'b00,9,1,0,0, 0,0,16'd7));
    tbl.push_back(mk(0,1,9,0,0,2'b00,5,1,0,0, 0,0,16'd7));
    // consumer two cycles after the load stalls once
    tbl.push_back(mk(0,1,0,0,1,2'b00,3,1,1,0, 0,0,16'd7));
    tbl.push_back(mk(0,0,0,0,0,2'b00,0,0,0,0, 0,1,16'd7));
    tbl.push_back(mk(0,1,3,0,1,2'b00,5,1,0,0, 1,1,16'd7));
    tbl.push_back(mk(0,1,3,0,1,2'b00,5,1,0,0, 0,0,16'd8));
    // reset in the middle of a stall
    tbl.push_back(mk(0,1,0,0,0,2'b00,8,1,1,0, 0,0,16'd8));
    tbl.push_back(mk(1,1,8,0,0,2'b00,5,1,0,0, 1,1,16'd8));
    tbl.push_back(mk(0,1,8,0,0,2'b00,5,1,0,0, 0,0,16'd0));
    tbl.push_back(mk(0,0,0,0,0,2'b00,0,0,0,0, 0,0,16'd0));

    @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      @(posedge clk);
      #1;
      v = tbl[i];
      v.idx = i;
      rst              = v.rst;
      u_if.dec_valid   = v.valid;
      u_if.dec_r2      = v.r2;
      u_if.dec_r3      = v.r3;
      u_if.dec_vf      = v.vf;
      u_if.dec_ext_sel = v.ext;
      u_if.dec_dest    = v.dest;
      u_if.dec_we      = v.we;
      u_if.dec_is_load = v.ld;
      u_if.mem_hold    = v.hold;
      sb.push_back(v);
    end
    @(negedge clk);
    #1;
    chk("scoreboard drained", sb.size(), 32'd0);

    // Saturation on a long-latency instance.
    @(posedge clk);
    #1;
    big_rst = 1'b0;
    big_drive(1'b1, 4'd0, 4'd1, 1'b1);
    @(negedge clk);
    chk("big first load stall", {31'd0, b_if.stall}, 32'd0);
    @(posedge clk);
    #1;
    big_drive(1'b1, 4'd1, 4'd5, 1'b0);
    n = 0;
    while (n < 50000) begin
      @(negedge clk);
      if (!b_if.stall) break;
      n++;
      @(posedge clk);
      #1;
    end
    chk("big stall run length", n, 32'd40000);
    chk("big count after run", {16'd0, b_if.stall_count}, 32'd40000);
    @(posedge clk);
    #1;
    big_drive(1'b1, 4'd0, 4'd1, 1'b1);
    @(posedge clk);
    #1;
    big_drive(1'b1, 4'd1, 4'd5, 1'b0);
    repeat (25534) @(posedge clk);
    @(negedge clk);
    chk("big count near limit", {16'd0, b_if.stall_count}, 32'h0000FFFE);
    chk("big stall near limit", {31'd0, b_if.stall}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("big count at limit", {16'd0, b_if.stall_count}, 32'h0000FFFF);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("big count saturated", {16'd0, b_if.stall_count}, 32'h0000FFFF);
    chk("big still stalling", {31'd0, b_if.stall}, 32'd1);
    @(posedge clk);
    #1;
    big_rst = 1'b1;
    @(posedge clk);
    #1;
    big_rst = 1'b0;
    @(negedge clk);
    chk("big stall after reset", {31'd0, b_if.stall}, 32'd0);
    chk("big count after reset", {16'd0, b_if.stall_count}, 32'd0);
    chk("big pending after reset", {31'd0, b_if.load_pending}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/load_use_hazard_unit.md
# load_use_hazard_unit

Decode-stage interlock for the vector ASIP pipeline; it is the producer-side counterpart of the EX/WB forwarding path. For every load it issues, the block tracks how long the destination register (scalar or vector bank) remains unavailable for forwarding. It stalls decode and injects a bubble into EX while the decoding instruction reads such a register. It also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- `NREG`, 16: registers per bank (scalar bank VF=0, vector bank VF=1); index width 4.
- `LOAD_LAT`, 2: cycles, after a load issues, before its result reaches the forwarding point.
- `CNT_W`, `$clog2(LOAD_LAT+1)`: width of each per-register countdown.

Ports:
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `dec_valid` input 1: a valid instruction is in decode.
- `dec_r2`, `dec_r3` input 4: source register indices.
- `dec_vf` input 1: bank select for sources and destination (1 = vector).
- `dec_ext_sel` input 2: operand-format select. R2 is read when `dec_ext_sel[1]==0`. R3 is read when `dec_ext_sel==2'b00`.
- `dec_dest` input 4: destination index.
- `dec_we` input 1: the instruction writes `dec_dest`.
- `dec_is_load` input 1: the instruction is a memory load.
- `mem_hold` input 1: global pipeline freeze (memory not ready).
- `stall` output 1: hold PC and IF/ID this cycle.
- `bubble` output 1: replace the ID/EX contents with a NOP this cycle.
- `load_pending` output 1: at least one countdown is nonzero.
- `stall_count` output 16: saturating count of hazard-stall cycles.

## Operation
Scoreboard:
- There are 2×NREG countdowns, `cnt[vf][idx]`, each CNT_W bits wide.
- A register is pending when its countdown is not 0.
- Register index 0 is never pending. Writes to index 0 are ignored.

Hazard detection (combinational):
- `hz2 = dec_r2!=0 & ~dec_ext_sel[1] & pending[dec_vf][dec_r2]`
- `hz3 = dec_r3!=0 & dec_ext_sel==2'b00 & pending[dec_vf][dec_r3]`
- `stall = bubble = dec_valid & (hz2 | hz3)`. This holds during `mem_hold` as well, for observation only.

Issue:
- An instruction issues in a cycle where `dec_valid & ~stall & ~mem_hold`.

Countdown update, evaluated per cycle:
1. `rst`: all countdowns go to 0. This has priority over everything else.
2. `mem_hold`: all countdowns hold. There is no issue and no decrement.
3. Otherwise:
   - Every nonzero countdown decrements by 1.
   - Then, if the issuing instruction has `dec_we & dec_is_load & dec_dest!=0`, `cnt[dec_vf][dec_dest] <= LOAD_LAT`. This overrides the decrement of that entry, including when the entry was already pending (a re-load restarts the countdown).
4. Non-load writes never set a countdown. The forwarding path covers them.

Stall counter:
- `stall_count` increments by 1 in each cycle where `stall & ~mem_hold`.
- It saturates at 16'hFFFF.

`load_pending` is the OR of all countdowns being nonzero, registered-state based (no combinational path from the `dec_*` inputs).

Banks are independent. Scalar R5 pending does not stall a read of vector R5.

## Timing
- Reset values: all countdowns 0, `stall_count` 0, `load_pending` 0. `stall` and `bubble` are 0 in the cycle after reset, for any inputs.
- Load-to-use, back-to-back dependent instruction:
  - Load issues at cycle t.
  - The dependent instruction is stalled in cycles t+1 … t+LOAD_LAT (countdown LOAD_LAT … 1).
  - It issues at t+LOAD_LAT+1.
  - Total bubbles: LOAD_LAT.
- A dependent instruction k cycles after the load stalls for max(0, LOAD_LAT−k+1) cycles.
- `mem_hold` cycles stretch the wall-clock stall without changing the stall count.
- Reset asserted mid-stall: countdowns clear at that edge, and the next cycle shows no stall.

## Test plan
- **Reset:** drive `rst` for 2 cycles with `dec_valid=1` reading R3 → `stall=0`, `stall_count=0`, `load_pending=0`.
- **Basic load-use:** LOAD_LAT=2. Load VF=1, dest=4, at t; next instruction reads R2=4, VF=1, ext_sel=00 → `stall=bubble=1` at t+1 and t+2, issues at t+3, `stall_count=2`.
- **Filtering:**
  - Same load, but the consumer reads with `dec_vf=0` → no stall.
  - ext_sel=2'b10 reading R2=4 → no stall.
  - ext_sel=2'b01 reading R3=4 → no stall.
  - R2=0 → no stall.
- **mem_hold during stall:** assert `mem_hold` for 3 cycles at t+1 → countdown holds at 2, `stall=1` throughout. `stall_count` does not change during the hold. The instruction issues 2 non-hold stall cycles later and `stall_count` ends at 2.
- **Re-load and non-load:**
  - Load dest=7 at t; an independent load to dest=7 issues at t+1 → countdown reset to 2, and a consumer stalls until t+3 inclusive.
  - An ALU write to dest=9 never sets `load_pending`.
- **Saturation/reset mid-stall:**
  - Preload `stall_count` near its limit by holding a hazard with a large stall run → the count stays at 16'hFFFF.
  - Assert `rst` during a stall → `stall=0` and all countdowns 0 on the next cycle.
